rotate_seq_ctrl: RTL and testbench

Sequencer for the WIDTH-bit circular rotate register datapath.
- Accepts a load value, a direction and a step count through a start pulse.
- Rotates the value by one position per clock until the count is exhausted, then pulses done.
- Owns the rotate register and presents its contents on data_out.
- Sits between a host/stimulus controller and downstream logic consuming rotated patterns.

---
 rtl/rot_pkg.sv | 13 +
 rtl/rot_step.sv | 19 +
 rtl/rotate_seq_ctrl.sv | 106 ++++++++++
 tb/tb_rotate_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate sequencer and its single-step rotator.
package rot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage : rot_pkg

// File: rtl/rot_step.sv
// Combinational single-position circular rotator: right = {d[0], d[W-1:1]}, left = {d[W-2:0], d[W-1]}.
module rot_step
   import rot_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_data_c
);

   logic [WIDTH-1:0] w_right;
   logic [WIDTH-1:0] w_left;

   assign w_right  = {i_data[0], i_data[WIDTH-1:1]};
   assign w_left   = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
   assign o_data_c = (i_dir == DIR_LEFT) ? w_left : w_right;

endmodule : rot_step

// File: rtl/rotate_seq_ctrl.sv
// Rotate sequencer: latches a pattern on start, rotates it one position per clock, pulses done.
// Optional macro ROT_HOLD_EN adds a hold input that stalls rotation while in ROTATE.
module rotate_seq_ctrl
   import rot_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   input  logic [CNT_W-1:0] steps,
`ifdef ROT_HOLD_EN
   input  logic             hold,
`endif
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_data_nxt;
   logic [WIDTH-1:0] w_rot;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_hold;

`ifdef ROT_HOLD_EN
   assign w_hold = hold;
`else
   assign w_hold = 1'b0;
`endif

   rot_step #(
      .WIDTH (WIDTH)
   ) u_rot_step (
      .i_data   (r_data),
      .i_dir    (r_dir),
      .o_data_c (w_rot)
   );

   // Next-state, datapath and counter decode
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_data_nxt  = load_val;
               w_cnt_nxt   = steps;
               w_dir_nxt   = dir;
               w_state_nxt = (steps != '0) ? ST_ROTATE : ST_DONE;
            end
         end
         ST_ROTATE: begin
            if (!w_hold) begin
               w_data_nxt = w_rot;
               w_cnt_nxt  = CNT_W'(r_cnt - CNT_W'(1));
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; busy/done registered from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_dir   <= DIR_RIGHT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   assign data_out = r_data;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule : rotate_seq_ctrl

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl; hold scenario is built only when ROT_HOLD_EN is defined.
module tb_rotate_seq_ctrl;

   localparam int unsigned WIDTH = 6;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             dir;
   logic [WIDTH-1:0] load_val;
   logic [CNT_W-1:0] steps;
`ifdef ROT_HOLD_EN
   logic             hold;
`endif
   logic [WIDTH-1:0] data_out;
   logic             busy;
   logic             done;

   int n_cmp;
   int n_err;
   int cyc;

   rotate_seq_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dir      (dir),
      .load_val (load_val),
      .steps    (steps),
`ifdef ROT_HOLD_EN
      .hold     (hold),
`endif
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge (T0) with the given transfer parameters
   task automatic run_seq(input logic [WIDTH-1:0] lv, input logic d, input logic [CNT_W-1:0] n);
      load_val = lv;
      dir      = d;
      steps    = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Edges until done is seen; -1 if the bound expires
   task automatic wait_done(output int c);
      c = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done === 1'b1) begin
            c = i;
            break;
         end
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dir      = 1'b0;
      load_val = '0;
      steps    = '0;
`ifdef ROT_HOLD_EN
      hold     = 1'b0;
`endif
      tick();
      tick();
      check("rst_data", int'(data_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      tick();

      // Right by 1
      run_seq(6'b110110, 1'b0, 4'd1);
      check("r1_t0_data", int'(data_out), 'b110110);
      check("r1_t0_busy", int'(busy), 1);
      check("r1_t0_done", int'(done), 0);
      tick();
      check("r1_t1_data", int'(data_out), 'b011011);
      check("r1_t1_done", int'(done), 1);
      tick();
      check("r1_end_done", int'(done), 0);
      check("r1_end_busy", int'(busy), 0);

      // Left by 2, single-cycle done
      run_seq(6'b001010, 1'b1, 4'd2);
      tick();
      check("l2_t1_data", int'(data_out), 'b010100);
      check("l2_t1_done", int'(done), 0);
      tick();
      check("l2_t2_data", int'(data_out), 'b101000);
      check("l2_t2_done", int'(done), 1);
      tick();
      check("l2_end_done", int'(done), 0);
      check("l2_end_busy", int'(busy), 0);

      // Counts of WIDTH and WIDTH+1
      run_seq(6'b110110, 1'b0, 4'd6);
      wait_done(cyc);
      check("r6_lat", cyc, 6);
      check("r6_data", int'(data_out), 'b110110);
      tick();
      run_seq(6'b110110, 1'b0, 4'd7);
      wait_done(cyc);
      check("r7_lat", cyc, 7);
      check("r7_data", int'(data_out), 'b011011);
      tick();

      // Zero steps, then idle hold
      run_seq(6'b100001, 1'b0, 4'd0);
      check("z_busy", int'(busy), 1);
      check("z_done", int'(done), 1);
      check("z_data", int'(data_out), 'b100001);
      tick();
      check("z_end_busy", int'(busy), 0);
      check("z_end_done", int'(done), 0);
      tick();
      tick();
      tick();
      check("idle_hold", int'(data_out), 'b100001);

      // start held during ROTATE and DONE is ignored; accepted in first IDLE cycle
      run_seq(6'b000011, 1'b1, 4'd4);
      start    = 1'b1;
      load_val = 6'b111111;
      dir      = 1'b0;
      steps    = 4'd15;
      wait_done(cyc);
      check("ign_lat", cyc, 4);
      check("ign_data", int'(data_out), 'b110000);
      tick();
      check("b2b_idle_busy", int'(busy), 0);
      check("b2b_idle_data", int'(data_out), 'b110000);
      tick();
      start = 1'b0;
      check("b2b_t0_busy", int'(busy), 1);
      check("b2b_t0_data", int'(data_out), 'b111111);
      wait_done(cyc);
      check("b2b_lat", cyc, 15);
      check("b2b_data", int'(data_out), 'b111111);
      tick();

      // Reset mid-rotation aborts without done
      run_seq(6'b000011, 1'b1, 4'd5);
      tick();
      tick();
      check("abort_pre", int'(data_out), 'b001100);
      rst_n = 1'b0;
      tick();
      check("abort_data", int'(data_out), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      rst_n = 1'b1;
      tick();
      tick();
      check("abort_post_done", int'(done), 0);
      check("abort_post_busy", int'(busy), 0);

`ifdef ROT_HOLD_EN
      // Two held cycles after T1 stretch completion by two
      run_seq(6'b110110, 1'b0, 4'd3);
      tick();
      check("h_t1_data", int'(data_out), 'b011011);
      hold = 1'b1;
      tick();
      check("h_frz1_data", int'(data_out), 'b011011);
      check("h_frz1_busy", int'(busy), 1);
      tick();
      check("h_frz2_data", int'(data_out), 'b011011);
      check("h_frz2_done", int'(done), 0);
      hold = 1'b0;
      wait_done(cyc);
      check("h_lat", cyc, 2);
      check("h_data", int'(data_out), 'b110110);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_rotate_seq_ctrl
